// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the raw I2C write transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        ADDR     = 3'd2,
        ADDR_ACK = 3'd3,
        LOAD     = 3'd4,
        DATA     = 3'd5,
        DATA_ACK = 3'd6,
        STOP     = 3'd7
    } i2c_state_t;

    localparam logic RW_WRITE         = 1'b0;
    localparam logic ACK              = 1'b0;
    localparam int   QUARTERS_PER_BIT = 4;

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_quarter_tick
//  Description : SCL quarter-period divider. Counts 0..CLK_DIV-1 while
//                enabled and ticks on the wrap cycle; restart forces 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int              c_cw   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

    logic [c_cw-1:0] r_count;

    assign tick = enable && (r_count == c_last);

    // Divider counter: restart has priority so every state entry begins at 0
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= tick ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_raw_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_raw_tx
//  Description : Bit-level I2C write master. Sends START, {addr,W}, len data
//                bytes MSB-first with ACK sampling, then STOP. SCL/SDA are
//                push-pull levels intended for a raw pattern monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_raw_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [3:0] len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    i2c_state_t  r_state;
    i2c_state_t  w_next;
    logic [1:0]  r_quarter;
    logic [2:0]  r_bitcnt;
    logic [3:0]  r_bytecnt;
    logic [7:0]  r_shift;
    logic        r_ack_smp;
    logic        r_nack;
    logic        r_done;

    logic        w_tick;
    logic        w_div_en;
    logic        w_restart;
    logic        w_bit_end;
    logic        w_ack_q2;

    // The divider is frozen while idle and while stretching in LOAD
    assign w_div_en  = (r_state != IDLE) && (r_state != LOAD);
    assign w_restart = (w_next != r_state);
    assign w_bit_end = w_tick && (r_quarter == 2'(QUARTERS_PER_BIT - 1));
    assign w_ack_q2  = w_tick && (r_quarter == 2'd2);

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_quarter_tick (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_div_en),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and line levels; bit cells put SCL high in quarters 2-3
    always_comb begin
        w_next   = r_state;
        scl      = 1'b1;
        sda      = 1'b1;
        tx_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = START;
            end
            START: begin
                sda = 1'b0;
                if (w_tick && (r_quarter == 2'd1)) w_next = ADDR;
            end
            ADDR: begin
                scl = r_quarter[1];
                sda = r_shift[7];
                if (w_bit_end && (r_bitcnt == 3'd0)) w_next = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl = r_quarter[1];
                if (w_bit_end) begin
                    if ((r_ack_smp == ACK) && (r_bytecnt != 4'd0)) w_next = LOAD;
                    else                                          w_next = STOP;
                end
            end
            LOAD: begin
                // SDA keeps the released level left by the preceding ACK bit
                scl      = 1'b0;
                tx_ready = 1'b1;
                if (tx_valid) w_next = DATA;
            end
            DATA: begin
                scl = r_quarter[1];
                sda = r_shift[7];
                if (w_bit_end && (r_bitcnt == 3'd0)) w_next = DATA_ACK;
            end
            DATA_ACK: begin
                scl = r_quarter[1];
                if (w_bit_end) begin
                    if ((r_ack_smp == ACK) && (r_bytecnt != 4'd0)) w_next = LOAD;
                    else                                          w_next = STOP;
                end
            end
            STOP: begin
                scl = (r_quarter != 2'd0);
                sda = (r_quarter == 2'd2);
                if (w_tick && (r_quarter == 2'd2)) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: quarter/bit/byte counters, shifter, ACK sample and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quarter <= 2'd0;
            r_bitcnt  <= 3'd0;
            r_bytecnt <= 4'd0;
            r_shift   <= 8'd0;
            r_ack_smp <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == STOP) && (w_next == IDLE);

            if (w_restart)   r_quarter <= 2'd0;
            else if (w_tick) r_quarter <= r_quarter + 2'd1;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= {addr, RW_WRITE};
                        r_bitcnt  <= 3'd7;
                        r_bytecnt <= len;
                        r_nack    <= 1'b0;
                    end
                end
                ADDR, DATA: begin
                    if (w_bit_end) begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 3'd1;
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (w_ack_q2) r_ack_smp <= sda_in;
                    if (w_bit_end && (r_ack_smp != ACK)) r_nack <= 1'b1;
                end
                LOAD: begin
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_bitcnt  <= 3'd7;
                        r_bytecnt <= r_bytecnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign nack = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_raw_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_raw_tx
//  Description : Directed self-checking bench for i2c_raw_tx (CLK_DIV=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_raw_tx;

    localparam int CD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] addr;
    logic [3:0] len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       sda_in;
    logic       scl;
    logic       sda;
    logic       busy;
    logic       done;
    logic       nack;

    int checks   = 0;
    int failures = 0;

    // Line monitor state
    logic [63:0] bits;
    int          nbits;
    int          nstart;
    int          nstop;
    int          nready;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;

    always #5 clk = ~clk;

    i2c_raw_tx #(
        .CLK_DIV (CD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (addr),
        .len      (len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sda_in   (sda_in),
        .scl      (scl),
        .sda      (sda),
        .busy     (busy),
        .done     (done),
        .nack     (nack)
    );

    // Capture SDA on SCL rising, count START/STOP-type edges and tx_ready cycles
    always @(negedge clk) begin
        if (!prev_scl && scl) begin
            bits  = {bits[62:0], sda};
            nbits = nbits + 1;
        end
        if (prev_scl && scl && prev_sda && !sda) nstart = nstart + 1;
        if (prev_scl && scl && !prev_sda && sda) nstop  = nstop + 1;
        if (tx_ready) nready = nready + 1;
        prev_scl = scl;
        prev_sda = sda;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        bits   = '0;
        nbits  = 0;
        nstart = 0;
        nstop  = 0;
        nready = 0;
    endtask

    // Holds start for one edge; returns in the first START cycle (k=1)
    task automatic launch(input logic [6:0] a, input logic [3:0] l);
        addr  = a;
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 1;
        while (done !== 1'b1 && k < 2000) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; addr = '0; len = '0;
        tx_data = '0; tx_valid = 1'b0; sda_in = 1'b0;
        repeat (3) step();
        checks++; if (scl !== 1'b1)      begin failures++; $display("FAIL reset_scl got=%b exp=1", scl); end
        checks++; if (sda !== 1'b1)      begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (nack !== 1'b0)     begin failures++; $display("FAIL reset_nack got=%b exp=0", nack); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_one();
        int k;
        clear_log();
        sda_in = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
        launch(7'h50, 4'd1);
        checks++; if ({scl, sda} !== 2'b10) begin failures++; $display("FAIL w1_start_cond got=%b exp=10", {scl, sda}); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL w1_busy got=%b exp=1", busy); end
        wait_done(k);
        checks++; if (k != 156) begin failures++; $display("FAIL w1_done_cycle got=%0d exp=156", k); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL w1_busy_at_done got=%b exp=0", busy); end
        checks++; if (nack !== 1'b0) begin failures++; $display("FAIL w1_nack got=%b exp=0", nack); end
        checks++; if (nbits != 19) begin failures++; $display("FAIL w1_nbits got=%0d exp=19", nbits); end
        checks++; if (bits[18:0] !== {8'hA0, 1'b1, 8'hA5, 1'b1, 1'b0})
            begin failures++; $display("FAIL w1_bits got=%h exp=%h", bits[18:0], {8'hA0, 1'b1, 8'hA5, 1'b1, 1'b0}); end
        checks++; if (nstart != 1 || nstop != 1)
            begin failures++; $display("FAIL w1_start_stop got=%0d/%0d exp=1/1", nstart, nstop); end
        checks++; if (nready != 1) begin failures++; $display("FAIL w1_ready_cycles got=%0d exp=1", nready); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL w1_done_pulse got=%b exp=0", done); end
        tx_valid = 1'b0;
    endtask

    task automatic test_addr_only();
        int k;
        clear_log();
        tx_valid = 1'b0; sda_in = 1'b0;
        launch(7'h7F, 4'd0);
        wait_done(k);
        checks++; if (k != 1 + 41 * CD) begin failures++; $display("FAIL a0_done_cycle got=%0d exp=%0d", k, 1 + 41 * CD); end
        checks++; if (nbits != 10 || bits[9:0] !== {8'hFE, 1'b1, 1'b0})
            begin failures++; $display("FAIL a0_bits got=%0d:%h exp=10:%h", nbits, bits[9:0], {8'hFE, 1'b1, 1'b0}); end
        checks++; if (nready != 0) begin failures++; $display("FAIL a0_ready_cycles got=%0d exp=0", nready); end
        checks++; if (nack !== 1'b0) begin failures++; $display("FAIL a0_nack got=%b exp=0", nack); end
    endtask

    task automatic test_nack();
        int k;
        clear_log();
        sda_in = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
        launch(7'h12, 4'd3);
        wait_done(k);
        checks++; if (k != 83) begin failures++; $display("FAIL nk_done_cycle got=%0d exp=83", k); end
        checks++; if (nack !== 1'b1) begin failures++; $display("FAIL nk_nack got=%b exp=1", nack); end
        checks++; if (nready != 0) begin failures++; $display("FAIL nk_ready_cycles got=%0d exp=0", nready); end
        checks++; if (nbits != 10 || bits[9:0] !== {8'h24, 1'b1, 1'b0})
            begin failures++; $display("FAIL nk_bits got=%0d:%h exp=10:%h", nbits, bits[9:0], {8'h24, 1'b1, 1'b0}); end
        step(); step();
        checks++; if (nack !== 1'b1) begin failures++; $display("FAIL nk_sticky got=%b exp=1", nack); end
        sda_in = 1'b0; tx_valid = 1'b0;
        launch(7'h01, 4'd0);
        checks++; if (nack !== 1'b0) begin failures++; $display("FAIL nk_clear got=%b exp=0", nack); end
        wait_done(k);
        checks++; if (k != 83 || nack !== 1'b0)
            begin failures++; $display("FAIL nk_followup got=%0d/%b exp=83/0", k, nack); end
    endtask

    task automatic test_stretch();
        int k, phase, stretch, bad;
        clear_log();
        sda_in = 1'b0; tx_data = 8'h3C; tx_valid = 1'b1;
        phase = 0; stretch = 0; bad = 0;
        launch(7'h2A, 4'd2);
        k = 1;
        while (done !== 1'b1 && k < 2000) begin
            if (phase == 0 && tx_ready) begin
                phase = 1;
            end else if (phase == 1) begin
                tx_valid = 1'b0;
                phase = 2;
            end else if (phase == 2 && tx_ready) begin
                if (stretch < 10) begin
                    if (tx_ready !== 1'b1 || scl !== 1'b0) bad++;
                    stretch++;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = 8'hC3;
                    phase    = 3;
                end
            end else if (phase == 3) begin
                tx_data = 8'hFF;
                phase   = 4;
            end
            step();
            k++;
        end
        checks++; if (bad != 0 || stretch != 10)
            begin failures++; $display("FAIL st_hold got=%0d bad/%0d cycles exp=0/10", bad, stretch); end
        checks++; if (k != 239) begin failures++; $display("FAIL st_done_cycle got=%0d exp=239", k); end
        checks++; if (nready != 12) begin failures++; $display("FAIL st_ready_cycles got=%0d exp=12", nready); end
        checks++; if (nbits != 28 || bits[27:0] !== {8'h54, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1, 1'b0})
            begin failures++; $display("FAIL st_bits got=%0d:%h exp=28:%h", nbits, bits[27:0], {8'h54, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1, 1'b0}); end
        tx_valid = 1'b0;
    endtask

    task automatic test_ignore();
        int k;
        clear_log();
        sda_in = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        launch(7'h33, 4'd1);
        k = 1;
        while (done !== 1'b1 && k < 2000) begin
            if (k == 20) begin
                start = 1'b1; addr = 7'h01; len = 4'd9;
                tx_valid = 1'b1; tx_data = 8'h00;
                checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL ig_ready_outside_load got=%b exp=0", tx_ready); end
            end else if (k == 21) begin
                start = 1'b0; tx_valid = 1'b0;
            end else if (k > 21 && tx_ready && !tx_valid) begin
                tx_valid = 1'b1; tx_data = 8'h5A;
            end
            step();
            k++;
        end
        checks++; if (k != 156) begin failures++; $display("FAIL ig_done_cycle got=%0d exp=156", k); end
        checks++; if (nbits != 19 || bits[18:0] !== {8'h66, 1'b1, 8'h5A, 1'b1, 1'b0})
            begin failures++; $display("FAIL ig_bits got=%0d:%h exp=19:%h", nbits, bits[18:0], {8'h66, 1'b1, 8'h5A, 1'b1, 1'b0}); end
        checks++; if (nstart != 1 || nready != 1)
            begin failures++; $display("FAIL ig_counts got=%0d start/%0d ready exp=1/1", nstart, nready); end
        tx_valid = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ig_no_restart got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_log();
        sda_in = 1'b0; tx_valid = 1'b1; tx_data = 8'h81;
        launch(7'h0F, 4'd1);
        repeat (89) step();
        checks++; if (busy !== 1'b1 || tx_ready !== 1'b0)
            begin failures++; $display("FAIL rm_in_data got=%b%b exp=10", busy, tx_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({scl, sda} !== 2'b11) begin failures++; $display("FAIL rm_lines got=%b exp=11", {scl, sda}); end
        checks++; if ({busy, done, nack, tx_ready} !== 4'b0000)
            begin failures++; $display("FAIL rm_status got=%b exp=0000", {busy, done, nack, tx_ready}); end
        tx_valid = 1'b0;
        step(); step();
        clear_log();
        launch(7'h50, 4'd0);
        wait_done(k);
        checks++; if (k != 83) begin failures++; $display("FAIL rm_rerun_cycle got=%0d exp=83", k); end
        checks++; if (nbits != 10 || bits[9:0] !== {8'hA0, 1'b1, 1'b0})
            begin failures++; $display("FAIL rm_rerun_bits got=%0d:%h exp=10:%h", nbits, bits[9:0], {8'hA0, 1'b1, 1'b0}); end
    endtask

    initial begin
        test_reset();
        test_write_one();
        test_addr_only();
        test_nack();
        test_stretch();
        test_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
